// File: rtl/jtframe_video_pkg.sv
// Shared video timing constants and the blanking/sync range rule used by the
// counter stage, the blanking delay stage and other video blocks.
package jtframe_video_pkg;

  typedef struct packed {
    int unsigned cnt_start;
    int unsigned cnt_end;
    int unsigned b_start;
    int unsigned b_end;
    int unsigned s_start;
    int unsigned s_end;
  } axis_timing_t;

  // 384 pixels per line with 256 visible; 262 lines per frame with 224 visible
  localparam axis_timing_t H_TIMING_384 = '{
    cnt_start: 0, cnt_end: 383, b_start: 256, b_end: 0, s_start: 300, s_end: 332
  };
  localparam axis_timing_t V_TIMING_262 = '{
    cnt_start: 0, cnt_end: 261, b_start: 224, b_end: 0, s_start: 240, s_end: 243
  };

  // 256x224 visible area shares the 384x262 totals
  localparam int unsigned VISIBLE_W_256 = 256;
  localparam int unsigned VISIBLE_H_224 = 224;

  // True for s <= x < e; the region wraps when s > e and is empty when s == e
  function automatic logic in_range(input int unsigned x,
                                    input int unsigned s,
                                    input int unsigned e);
    if (s == e)     return 1'b0;
    else if (s < e) return (x >= s) && (x < e);
    else            return (x >= s) || (x < e);
  endfunction

endpackage

// File: rtl/jtframe_blank_cnt.sv
// One timing axis: wrapping counter plus registered blank/sync flags that are
// decoded from the next count so they line up with the counter output.
module jtframe_blank_cnt
  import jtframe_video_pkg::*;
#(
  parameter int          W       = 9,
  parameter int unsigned START   = 0,
  parameter int unsigned END     = 383,
  parameter int unsigned B_START = 256,
  parameter int unsigned B_END   = 0,
  parameter int unsigned S_START = 300,
  parameter int unsigned S_END   = 332
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic         advance,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt,
  output logic         wrap,
  output logic         blank_n,
  output logic         sync
);

  localparam logic [W-1:0] START_V = W'(START);
  localparam logic [W-1:0] END_V   = W'(END);

  if (64'(END) >= (64'd1 << W)) begin : g_bad_range
    $fatal(1, "jtframe_blank_cnt: END=%0d does not fit in %0d bits", END, W);
  end

  always_comb begin
    wrap = (cnt == END_V);
    nxt  = cnt;
    if (advance) nxt = wrap ? START_V : cnt + 1'b1;
  end

  // Flags refresh on every enable (not only on advance) so the first enable
  // after reset already yields correct values on the slow axis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= START_V;
      blank_n <= 1'b0;
      sync    <= 1'b0;
    end else if (cen) begin
      cnt     <= nxt;
      blank_n <= !in_range(32'(nxt), B_START, B_END);
      sync    <= in_range(32'(nxt), S_START, S_END);
    end
  end

endmodule

// File: rtl/jtframe_blank_gen.sv
// Video timing generator: H/V counters with registered blanking, sync and
// frame-start flags, all consistent with the counter values of the same cycle.
module jtframe_blank_gen
  import jtframe_video_pkg::*;
#(
  parameter int          HW         = 9,
  parameter int          VW         = 9,
  parameter int unsigned HCNT_START = 0,
  parameter int unsigned HCNT_END   = 383,
  parameter int unsigned HB_START   = 256,
  parameter int unsigned HB_END     = 0,
  parameter int unsigned HS_START   = 300,
  parameter int unsigned HS_END     = 332,
  parameter int unsigned VCNT_START = 0,
  parameter int unsigned VCNT_END   = 261,
  parameter int unsigned VB_START   = 224,
  parameter int unsigned VB_END     = 0,
  parameter int unsigned VS_START   = 240,
  parameter int unsigned VS_END     = 243
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  output logic [HW-1:0] H,
  output logic [VW-1:0] V,
  output logic          Hinit,
  output logic          Vinit,
  output logic          LHBL,
  output logic          LVBL,
  output logic          HS,
  output logic          VS
);

  localparam logic [HW-1:0] H_START_V = HW'(HCNT_START);
  localparam logic [VW-1:0] V_START_V = VW'(VCNT_START);

  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          h_wrap;
  logic          v_wrap;

  jtframe_blank_cnt #(
    .W      (HW),
    .START  (HCNT_START),
    .END    (HCNT_END),
    .B_START(HB_START),
    .B_END  (HB_END),
    .S_START(HS_START),
    .S_END  (HS_END)
  ) u_hcnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (pxl_cen),
    .advance(pxl_cen),
    .cnt    (H),
    .nxt    (h_nxt),
    .wrap   (h_wrap),
    .blank_n(LHBL),
    .sync   (HS)
  );

  jtframe_blank_cnt #(
    .W      (VW),
    .START  (VCNT_START),
    .END    (VCNT_END),
    .B_START(VB_START),
    .B_END  (VB_END),
    .S_START(VS_START),
    .S_END  (VS_END)
  ) u_vcnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (pxl_cen),
    .advance(pxl_cen & h_wrap),
    .cnt    (V),
    .nxt    (v_nxt),
    .wrap   (v_wrap),
    .blank_n(LVBL),
    .sync   (VS)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Hinit <= 1'b1;
      Vinit <= 1'b1;
    end else if (pxl_cen) begin
      Hinit <= (h_nxt == H_START_V);
      Vinit <= (h_nxt == H_START_V) && (v_nxt == V_START_V);
    end
  end

  logic unused;
  assign unused = v_wrap;

endmodule

// File: tb/tb_jtframe_blank_gen.sv
// Bench for jtframe_blank_gen: small 10x6 frame, reference derived from the
// number of enabled pixels since reset.
module tb_jtframe_blank_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pxl_cen;
  logic [8:0] H, V, d_H, d_V;
  logic       Hinit, Vinit, LHBL, LVBL, HS, VS;
  logic       d_Hinit, d_Vinit, d_LHBL, d_LVBL, d_HS, d_VS;

  int n;
  bit fresh;
  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  jtframe_blank_gen #(
    .HW(9), .VW(9),
    .HCNT_START(0), .HCNT_END(9), .HB_START(8), .HB_END(2), .HS_START(5), .HS_END(7),
    .VCNT_START(0), .VCNT_END(5), .VB_START(4), .VB_END(0), .VS_START(4), .VS_END(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .H(H), .V(V),
    .Hinit(Hinit), .Vinit(Vinit), .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS)
  );

  jtframe_blank_gen #(
    .HW(9), .VW(9),
    .HCNT_START(0), .HCNT_END(9), .HB_START(3), .HB_END(3), .HS_START(5), .HS_END(7),
    .VCNT_START(0), .VCNT_END(5), .VB_START(4), .VB_END(0), .VS_START(4), .VS_END(5)
  ) dut_deg (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .H(d_H), .V(d_V),
    .Hinit(d_Hinit), .Vinit(d_Vinit), .LHBL(d_LHBL), .LVBL(d_LVBL), .HS(d_HS), .VS(d_VS)
  );

  function automatic bit rng(int x, int s, int e);
    if (s == e)     return 1'b0;
    else if (s < e) return (x >= s) && (x < e);
    else            return (x >= s) || (x < e);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  task automatic check_all();
    int h, v;
    h = n % 10;
    v = (n / 10) % 6;
    chk("H", 32'(H), h);
    chk("V", 32'(V), v);
    chk("Hinit", 32'(Hinit), fresh ? 1 : int'(h == 0));
    chk("Vinit", 32'(Vinit), fresh ? 1 : int'(h == 0 && v == 0));
    chk("LHBL", 32'(LHBL), fresh ? 0 : int'(!rng(h, 8, 2)));
    chk("HS", 32'(HS), fresh ? 0 : int'(rng(h, 5, 7)));
    chk("LVBL", 32'(LVBL), fresh ? 0 : int'(!rng(v, 4, 0)));
    chk("VS", 32'(VS), fresh ? 0 : int'(rng(v, 4, 5)));
    chk("deg_H", 32'(d_H), h);
    chk("deg_LHBL", 32'(d_LHBL), fresh ? 0 : 1);
  endtask

  task automatic step(bit cen);
    pxl_cen = cen;
    @(posedge clk);
    if (cen) begin
      n++;
      fresh = 1'b0;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n   = 1'b0;
    pxl_cen = 1'b0;
    n       = 0;
    fresh   = 1'b1;
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    repeat (3) step(1'b0);

    // Run to H=6, V=3 then pull reset between edges
    repeat (36) step(1'b1);
    #2 rst_n = 1'b0;
    #1;
    n     = 0;
    fresh = 1'b1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // Enable every third clock across more than a full line
    for (int i = 0; i < 36; i++) step(i % 3 == 2);

    // Random enable pattern spanning several frames
    for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 1)));

    // Freeze mid-line, then resume
    for (int i = 0; i < 20 && (n % 10) != 4; i++) step(1'b1);
    repeat (50) step(1'b0);
    step(1'b1);

    // Land on H=9, V=5 and take the simultaneous wrap
    for (int i = 0; i < 60 && (n % 60) != 59; i++) step(1'b1);
    chk("pre_wrap_H", 32'(H), 9);
    chk("pre_wrap_V", 32'(V), 5);
    step(1'b1);
    chk("wrap_Vinit", 32'(Vinit), 1);
    chk("wrap_LVBL", 32'(LVBL), 1);

    // One more full frame with continuous enable
    repeat (60) step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/jtframe_blank_gen.md
Name: jtframe_blank_gen

Overview:
Video timing generator that produces the LHBL/LVBL blanking pair, sync pulses and pixel/line counters consumed by the blanking/RGB path of each core.
- Horizontal counter advances on pxl_cen; vertical counter advances on horizontal wrap.
- All timing is parameterised, so cores instantiate it instead of hand-coding counters.
- Sits at the head of the video chain; its LHBL/LVBL feed the blanking delay stage, which then gates the RGB.

Parameters:
HW, 9, horizontal counter width
VW, 9, vertical counter width
HCNT_START, 0, first H value after wrap
HCNT_END, 383, last H value before wrap
HB_START, 256, first blanked H (inclusive)
HB_END, 0, first visible H after blank (exclusive end)
HS_START, 300, first H with HS high
HS_END, 332, first H with HS low again
VCNT_START, 0, first V value after wrap
VCNT_END, 261, last V value before wrap
VB_START, 224, first blanked line
VB_END, 0, first visible line after blank
VS_START, 240, first line with VS high
VS_END, 243, first line with VS low again

Ports:
clk      in   1   system clock
rst_n    in   1   asynchronous active-low reset
pxl_cen  in   1   pixel clock enable; all state advances only when high
H        out  HW  horizontal counter
V        out  VW  vertical counter
Hinit    out  1   high while H==HCNT_START
Vinit    out  1   high while V==VCNT_START and H==HCNT_START
LHBL     out  1   horizontal blank, active low
LVBL     out  1   vertical blank, active low
HS       out  1   horizontal sync, active high
VS       out  1   vertical sync, active high

Behaviour:
- Single clock (clk). Reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset values, applied immediately on rst_n low, even mid-frame:
  - H=HCNT_START, V=VCNT_START
  - Hinit=1, Vinit=1
  - LHBL=0, LVBL=0, HS=0, VS=0
- Clock edge with pxl_cen=0: nothing changes.
- Clock edge with pxl_cen=1:
  - H <= (H==HCNT_END) ? HCNT_START : H+1.
  - On H wrap: V <= (V==VCNT_END) ? VCNT_START : V+1. Otherwise V holds.
- Range rule R(x, S, E):
  - S==E: always false.
  - S<E: true for S <= x < E.
  - S>E: true for x >= S or x < E (wrap-around region).
- Outputs are updated on the same edge as the counters and computed from the next counter values, so every output is consistent with H/V in the same cycle. Latency from counter to flag is 0 pixels.
  - LHBL = !R(Hnext, HB_START, HB_END)
  - HS = R(Hnext, HS_START, HS_END)
  - LVBL = !R(Vnext, VB_START, VB_END)
  - VS = R(Vnext, VS_START, VS_END)
- LVBL and VS can change only on the H-wrap edge.
- Hinit/Vinit are decoded from the next values in the same way.
- Counter arithmetic is modulo 2^HW / 2^VW. Parameters outside counter range are a configuration error. Simulation prints a fatal message if HCNT_END >= 2^HW or VCNT_END >= 2^VW.
- Simultaneous H wrap and V wrap: both counters load their start values on the same edge; Vinit=1 on that edge.
- Reset release: the first pxl_cen moves H to HCNT_START+1 with correct flags. No extra warm-up cycles.
- pxl_cen may have any duty cycle, including every clk; behaviour is defined per enabled edge only.

Decomposition:
- Shared package/include jtframe_video_pkg:
  - default timing constants for common 384x262 and 256x224 modes
  - a range-check function implementing R(x,S,E), so the blanking delay stage and other video blocks share the same rule
- Sub-module jtframe_blank_cnt (parameters W, START, END, B_START, B_END, S_START, S_END; input advance; outputs cnt, wrap, blank_n, sync).
  - Instantiated twice: the horizontal instance advances on pxl_cen; the vertical instance advances on pxl_cen & horizontal wrap.

Test Plan:
1. Reset: params H 0..9, V 0..5; run to H=6,V=3, assert rst_n=0 between clk edges -> H=0, V=0, LHBL=0, LVBL=0, HS=0, VS=0 immediately, without waiting for a clk edge.
2. Enable gating: pxl_cen high every 3rd clk, H 0..9 -> H steps once per 3 clk; sequence 0,1,…,9,0; Hinit high only while H=0.
3. Wrapped H blank: HB_START=8, HB_END=2 -> LHBL=0 exactly for H=8,9,0,1 and 1 elsewhere; HS_START=5, HS_END=7 -> HS=1 for H=5,6 only.
4. Vertical: VCNT 0..5, VB_START=4, VB_END=0, VS_START=4, VS_END=5 -> LVBL=0 for V=4,5; VS=1 for V=4; from H=9,V=5 the next pxl_cen gives H=0, V=0, Vinit=1, LVBL=1.
5. Freeze: hold pxl_cen=0 for 50 clk mid-line -> all outputs constant, then resume at the next H value.
6. Degenerate: HB_START==HB_END=3 -> LHBL stays 1 over a full line (after the first pxl_cen).
